pdu_ctrl: RTL

//  Debug-unit controller consuming the debounced, edge-detected one-cycle pulses from the button/switch front end.

---
 rtl/pdu_pkg.sv | 33 +++
 rtl/pdu_entry_buf.sv | 76 +++++++
 rtl/pdu_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/pdu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pdu_pkg
//  Description : Shared definitions for the debug-unit controller. This
//                includes the state encodings, default widths and the
//                hex-digit priority encoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package pdu_pkg;

    localparam int c_data_w_def = 32;
    localparam int c_addr_w_def = 8;
    localparam int c_ndig_w     = 4;
    localparam int c_mode_w     = 3;

    // State codes double as the status-LED mode value.
    localparam logic [c_mode_w-1:0] c_st_pause = 3'd0;
    localparam logic [c_mode_w-1:0] c_st_step  = 3'd1;
    localparam logic [c_mode_w-1:0] c_st_run   = 3'd2;
    localparam logic [c_mode_w-1:0] c_st_wait  = 3'd3;
    localparam logic [c_mode_w-1:0] c_st_chk   = 3'd4;

    // Index of the lowest set bit. When several keys pulse together,
    // the smallest digit is the one that is taken.
    function automatic logic [3:0] lowest_set(input logic [15:0] v);
        lowest_set = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) lowest_set = 4'(i);
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/pdu_entry_buf.sv
`default_nettype none
// ============================================================================
//  Module      : pdu_entry_buf
//  Description : Hex entry buffer for the debug unit. Digits shift in from
//                the right, a delete shifts them back out, and enter commits
//                the buffer as the pending CPU input word.
//  Revision    : 1.0 - initial release
// ============================================================================
module pdu_entry_buf
    import pdu_pkg::*;
#(
    parameter int DATA_W = c_data_w_def
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [15:0]         hd_ps,
    input  logic                del_ps,
    input  logic                ent_ps,
    input  logic                consume,
    output logic [DATA_W-1:0]   ebuf,
    output logic [c_ndig_w-1:0] ndig,
    output logic [DATA_W-1:0]   in_data,
    output logic                in_pend
);

    localparam logic [c_ndig_w-1:0] c_max_dig = c_ndig_w'(DATA_W / 4);

    logic [DATA_W-1:0]   r_ebuf;
    logic [c_ndig_w-1:0] r_ndig;
    logic [DATA_W-1:0]   r_in_data;
    logic                r_in_pend;
    logic [3:0]          w_digit;
    logic                w_hd_any;

    assign w_digit  = lowest_set(hd_ps);
    assign w_hd_any = |hd_ps;

    // Buffer edits: enter beats delete beats digit, and the losers are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ebuf    <= '0;
            r_ndig    <= '0;
            r_in_data <= '0;
        end else if (ent_ps) begin
            r_in_data <= r_ebuf;
            r_ebuf    <= '0;
            r_ndig    <= '0;
        end else if (del_ps) begin
            if (r_ndig != '0) begin
                r_ebuf <= r_ebuf >> 4;
                r_ndig <= r_ndig - 1'b1;
            end
        end else if (w_hd_any && (r_ndig < c_max_dig)) begin
            r_ebuf <= {r_ebuf[DATA_W-5:0], w_digit};
            r_ndig <= r_ndig + 1'b1;
        end
    end

    // Pending flag: a fresh commit wins over a same-cycle consume.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_pend <= 1'b0;
        end else if (ent_ps) begin
            r_in_pend <= 1'b1;
        end else if (consume) begin
            r_in_pend <= 1'b0;
        end
    end

    assign ebuf    = r_ebuf;
    assign ndig    = r_ndig;
    assign in_data = r_in_data;
    assign in_pend = r_in_pend;

endmodule
`default_nettype wire

// File: rtl/pdu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pdu_ctrl
//  Description : Debug-unit controller. It gates the CPU clock enable for
//                pause, single-step and run modes, stalls CPU input reads
//                until a word is entered, and holds the inspection address.
//  Revision    : 1.0 - initial release
// ============================================================================
module pdu_ctrl
    import pdu_pkg::*;
#(
    parameter int DATA_W = c_data_w_def,
    parameter int ADDR_W = c_addr_w_def
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                step_ps,
    input  logic                cont_ps,
    input  logic                chk_ps,
    input  logic                ent_ps,
    input  logic                del_ps,
    input  logic [15:0]         hd_ps,
    input  logic                io_rd,
    output logic                cpu_en,
    output logic [DATA_W-1:0]   in_data,
    output logic                in_pend,
    output logic [DATA_W-1:0]   ebuf,
    output logic [c_ndig_w-1:0] ndig,
    output logic [ADDR_W-1:0]   chk_addr,
    output logic [c_mode_w-1:0] mode
);

    logic [c_mode_w-1:0] r_state;
    logic [c_mode_w-1:0] w_state_nxt;
    logic [ADDR_W-1:0]   r_chk_addr;
    logic                w_cpu_en;
    logic                w_consume;
    logic                w_rd_stall;

    // A read with nothing pending has to stall the CPU in the same cycle.
    assign w_rd_stall = io_rd & ~in_pend;
    assign w_consume  = w_cpu_en & io_rd & in_pend;

    pdu_entry_buf #(
        .DATA_W (DATA_W)
    ) u_entry_buf (
        .clk     (clk),
        .rst     (rst),
        .hd_ps   (hd_ps),
        .del_ps  (del_ps),
        .ent_ps  (ent_ps),
        .consume (w_consume),
        .ebuf    (ebuf),
        .ndig    (ndig),
        .in_data (in_data),
        .in_pend (in_pend)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_pause;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_pause: begin
                if (step_ps)      w_state_nxt = c_st_step;
                else if (cont_ps) w_state_nxt = c_st_run;
                else if (chk_ps)  w_state_nxt = c_st_chk;
            end
            c_st_step:  w_state_nxt = c_st_pause;
            c_st_run: begin
                if (cont_ps)         w_state_nxt = c_st_pause;
                else if (w_rd_stall) w_state_nxt = c_st_wait;
            end
            c_st_wait: begin
                if (cont_ps)      w_state_nxt = c_st_pause;
                else if (in_pend) w_state_nxt = c_st_run;
            end
            c_st_chk: begin
                if (step_ps || cont_ps) w_state_nxt = c_st_pause;
            end
            default:    w_state_nxt = c_st_pause;
        endcase
    end

    // Output logic: exactly one enable cycle per step, and run mode is gated by read stalls.
    always_comb begin
        w_cpu_en = 1'b0;
        if (r_state == c_st_step) begin
            w_cpu_en = 1'b1;
        end else if (r_state == c_st_run) begin
            w_cpu_en = ~w_rd_stall;
        end
    end

    // The inspection address is seeded from the entry buffer and stepped in check mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_chk_addr <= '0;
        end else if (r_state == c_st_pause) begin
            if (chk_ps && !step_ps && !cont_ps) begin
                r_chk_addr <= ebuf[ADDR_W-1:0];
            end
        end else if (r_state == c_st_chk) begin
            if (ent_ps) begin
                r_chk_addr <= ebuf[ADDR_W-1:0];
            end else if (chk_ps && !step_ps && !cont_ps) begin
                r_chk_addr <= r_chk_addr + 1'b1;
            end
        end
    end

    assign cpu_en   = w_cpu_en;
    assign chk_addr = r_chk_addr;
    assign mode     = r_state;

endmodule
`default_nettype wire
